// File: rtl/seg_display_arbiter.sv
// ---------------------------------------------------------------------------
// seg_display_arbiter
//
// Purpose:
//   Shares one 8-digit seven-segment display between 4 requesters using
//   round-robin arbitration. The current owner's 8 segment bytes are
//   registered and driven to the display scanner. When other clients are
//   waiting, the owner is pre-empted after a minimum time quantum. Every
//   handover inserts a blank gap.
//
// Ports:
//   iCLK          in   1   system clock, all logic on posedge
//   nRST          in   1   synchronous, active-low reset
//   iREQ          in   4   level request per client
//   iDATA0..3     in   64  client digit bytes, [63:56]=digit7 .. [7:0]=digit0
//   oGNT          out  4   one-hot grant, zero when there is no owner
//   oOWNER        out  2   index of the current or last owner
//   oBUSY         out  1   high while a client owns the display
//   oSEG7..oSEG0  out  8   registered digit bytes to the scanner
// ---------------------------------------------------------------------------
module seg_display_arbiter #(
    parameter logic [31:0] QUANTUM    = 32'd50000,
    parameter logic [31:0] GAP_CYCLES = 32'd4,
    parameter logic [7:0]  BLANK      = 8'h00
) (
    input  logic        iCLK,
    input  logic        nRST,
    input  logic [3:0]  iREQ,
    input  logic [63:0] iDATA0,
    input  logic [63:0] iDATA1,
    input  logic [63:0] iDATA2,
    input  logic [63:0] iDATA3,
    output logic [3:0]  oGNT,
    output logic [1:0]  oOWNER,
    output logic        oBUSY,
    output logic [7:0]  oSEG7,
    output logic [7:0]  oSEG6,
    output logic [7:0]  oSEG5,
    output logic [7:0]  oSEG4,
    output logic [7:0]  oSEG3,
    output logic [7:0]  oSEG2,
    output logic [7:0]  oSEG1,
    output logic [7:0]  oSEG0
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OWN    = 2'd1,
        ST_SWITCH = 2'd2
    } state_t;

    // State registers
    state_t      r_state;
    logic [3:0]  r_gnt;
    logic [1:0]  r_owner;
    logic [1:0]  r_last_owner;
    logic        r_busy;
    logic [31:0] r_cnt;
    logic [31:0] r_gap_cnt;
    logic [7:0]  r_seg [0:7];

    // Next-state values
    state_t      w_state_next;
    logic [3:0]  w_gnt_next;
    logic [1:0]  w_owner_next;
    logic [1:0]  w_last_owner_next;
    logic        w_busy_next;
    logic [31:0] w_cnt_next;
    logic [31:0] w_gap_cnt_next;
    logic [7:0]  w_seg_next [0:7];

    // Datapath helpers
    logic [63:0] w_data [0:3];
    logic [63:0] w_owner_data;
    logic [7:0]  w_owner_byte [0:7];
    logic        w_rr_found;
    logic [1:0]  w_rr_win;
    logic        w_others_req;
    logic        w_cnt_max;
    logic        w_gap_end;
    logic        w_take;

    assign w_data[0] = iDATA0;
    assign w_data[1] = iDATA1;
    assign w_data[2] = iDATA2;
    assign w_data[3] = iDATA3;

    // Only the owner's bytes ever reach the display.
    assign w_owner_data = w_data[r_owner];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_byte
            assign w_owner_byte[gi] = w_owner_data[8*gi +: 8];
        end
    endgenerate

    // Round-robin search starting just after the last owner. The loop runs
    // from the farthest candidate to the nearest so that the nearest
    // asserted request is the one left standing. Offset 4 wraps back to the
    // last owner itself, so a pre-empted owner is always ranked last.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_win   = 2'd0;
        for (int i = 4; i >= 1; i--) begin
            if (iREQ[r_last_owner + 2'(i)]) begin
                w_rr_found = 1'b1;
                w_rr_win   = r_last_owner + 2'(i);
            end
        end
    end

    // r_gnt is one-hot on the owner while in OWN, so this masks out the owner.
    assign w_others_req = |(iREQ & ~r_gnt);
    assign w_cnt_max    = (r_cnt == QUANTUM - 32'd1);
    assign w_gap_end    = (r_gap_cnt == GAP_CYCLES - 32'd1);

    // Next-state and output logic
    always_comb begin
        w_state_next      = r_state;
        w_gnt_next        = r_gnt;
        w_owner_next      = r_owner;
        w_last_owner_next = r_last_owner;
        w_busy_next       = r_busy;
        w_cnt_next        = r_cnt;
        w_gap_cnt_next    = r_gap_cnt;
        w_take            = 1'b0;
        for (int k = 0; k < 8; k++) begin
            w_seg_next[k] = r_seg[k];
        end

        case (r_state)
            ST_IDLE: begin
                w_gnt_next  = 4'd0;
                w_busy_next = 1'b0;
                for (int k = 0; k < 8; k++) begin
                    w_seg_next[k] = BLANK;
                end
                w_take = w_rr_found;
            end

            ST_OWN: begin
                for (int k = 0; k < 8; k++) begin
                    w_seg_next[k] = w_owner_byte[k];
                end
                w_cnt_next = w_cnt_max ? r_cnt : r_cnt + 32'd1;
                // Voluntary release and quantum expiry take the same path.
                if (!iREQ[r_owner] || (w_cnt_max && w_others_req)) begin
                    w_state_next   = ST_SWITCH;
                    w_gnt_next     = 4'd0;
                    w_busy_next    = 1'b0;
                    w_gap_cnt_next = 32'd0;
                    for (int k = 0; k < 8; k++) begin
                        w_seg_next[k] = BLANK;
                    end
                end
            end

            ST_SWITCH: begin
                w_gnt_next  = 4'd0;
                w_busy_next = 1'b0;
                for (int k = 0; k < 8; k++) begin
                    w_seg_next[k] = BLANK;
                end
                // Requests are only looked at on the edge closing the gap.
                if (w_gap_end) begin
                    w_state_next = ST_IDLE;
                    w_take       = w_rr_found;
                end else begin
                    w_gap_cnt_next = r_gap_cnt + 32'd1;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
                w_gnt_next   = 4'd0;
                w_busy_next  = 1'b0;
            end
        endcase

        // Common grant path from IDLE and from the end of a gap. The display
        // stays blank on this edge; owner bytes follow one edge later.
        if (w_take) begin
            w_state_next      = ST_OWN;
            w_gnt_next        = 4'b0001 << w_rr_win;
            w_owner_next      = w_rr_win;
            w_last_owner_next = w_rr_win;
            w_busy_next       = 1'b1;
            w_cnt_next        = 32'd0;
        end
    end

    // State register
    always_ff @(posedge iCLK) begin
        if (!nRST) begin
            r_state      <= ST_IDLE;
            r_gnt        <= 4'd0;
            r_owner      <= 2'd0;
            r_last_owner <= 2'd3;
            r_busy       <= 1'b0;
            r_cnt        <= 32'd0;
            r_gap_cnt    <= 32'd0;
            for (int k = 0; k < 8; k++) begin
                r_seg[k] <= BLANK;
            end
        end else begin
            r_state      <= w_state_next;
            r_gnt        <= w_gnt_next;
            r_owner      <= w_owner_next;
            r_last_owner <= w_last_owner_next;
            r_busy       <= w_busy_next;
            r_cnt        <= w_cnt_next;
            r_gap_cnt    <= w_gap_cnt_next;
            for (int k = 0; k < 8; k++) begin
                r_seg[k] <= w_seg_next[k];
            end
        end
    end

    assign oGNT   = r_gnt;
    assign oOWNER = r_owner;
    assign oBUSY  = r_busy;
    assign oSEG0  = r_seg[0];
    assign oSEG1  = r_seg[1];
    assign oSEG2  = r_seg[2];
    assign oSEG3  = r_seg[3];
    assign oSEG4  = r_seg[4];
    assign oSEG5  = r_seg[5];
    assign oSEG6  = r_seg[6];
    assign oSEG7  = r_seg[7];

endmodule

// File: tb/tb_seg_display_arbiter.sv
// ---------------------------------------------------------------------------
// tb_seg_display_arbiter
//
// Purpose:
//   Directed self-checking bench for seg_display_arbiter with QUANTUM=8,
//   GAP_CYCLES=2, BLANK=8'h00. Outputs are sampled 1 time unit after each
//   rising edge; inputs are changed at the same point.
// ---------------------------------------------------------------------------
module tb_seg_display_arbiter;

    localparam logic [63:0] D0     = 64'h0102030405060708;
    localparam logic [63:0] D0_ALT = 64'hA1A2A3A4A5A6A7A8;
    localparam logic [63:0] D1     = 64'h1112131415161718;
    localparam logic [63:0] D2     = 64'h2122232425262728;
    localparam logic [63:0] D3     = 64'h3132333435363738;

    logic        clk;
    logic        n_rst;
    logic [3:0]  req;
    logic [63:0] data0, data1, data2, data3;
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic        busy;
    logic [7:0]  seg7, seg6, seg5, seg4, seg3, seg2, seg1, seg0;
    logic [63:0] segs;

    int n_cmp = 0;
    int n_err = 0;

    seg_display_arbiter #(
        .QUANTUM    (32'd8),
        .GAP_CYCLES (32'd2),
        .BLANK      (8'h00)
    ) dut (
        .iCLK   (clk),
        .nRST   (n_rst),
        .iREQ   (req),
        .iDATA0 (data0),
        .iDATA1 (data1),
        .iDATA2 (data2),
        .iDATA3 (data3),
        .oGNT   (gnt),
        .oOWNER (owner),
        .oBUSY  (busy),
        .oSEG7  (seg7),
        .oSEG6  (seg6),
        .oSEG5  (seg5),
        .oSEG4  (seg4),
        .oSEG3  (seg3),
        .oSEG2  (seg2),
        .oSEG1  (seg1),
        .oSEG0  (seg0)
    );

    assign segs = {seg7, seg6, seg5, seg4, seg3, seg2, seg1, seg0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        $display("[%0t] %s observed=%h expected=%h", $time, tag, obs, exp);
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_ctl(input string tag, input logic [3:0] e_gnt,
                             input logic [1:0] e_owner, input logic e_busy);
        check({tag, ".gnt"},   64'(gnt),   64'(e_gnt));
        check({tag, ".owner"}, 64'(owner), 64'(e_owner));
        check({tag, ".busy"},  64'(busy),  64'(e_busy));
    endtask

    int          order [7] = '{0, 1, 2, 3, 0, 1, 2};
    logic [63:0] dtab  [4] = '{D0, D1, D2, D3};

    initial begin
        n_rst = 1'b0;
        req   = 4'hF;
        data0 = D0;
        data1 = D1;
        data2 = D2;
        data3 = D3;

        // 1: reset held for two edges with all clients requesting
        step(2);
        check_ctl("reset", 4'b0000, 2'd0, 1'b0);
        check("reset.segs", segs, 64'h0);

        // First edge after release: client 0 wins, display still blank
        n_rst = 1'b1;
        step(1);
        check_ctl("first_grant", 4'b0001, 2'd0, 1'b1);
        check("first_grant.segs", segs, 64'h0);

        // 2: single requester, data appears one edge after the grant
        req = 4'b0001;
        step(1);
        check("single.segs", segs, D0);
        data0 = D0_ALT;
        step(1);
        check("single.live_data", segs, D0_ALT);
        data0 = D0;
        // Sole requester keeps the display well past the quantum
        step(10);
        check_ctl("single.hold", 4'b0001, 2'd0, 1'b1);
        check("single.hold.segs", segs, D0);

        // 3: pre-emption once another client asks after the quantum expired
        req = 4'b0011;
        step(1);
        check_ctl("preempt.switch", 4'b0000, 2'd0, 1'b0);
        check("preempt.switch.segs", segs, 64'h0);
        step(1);
        check("preempt.gap2.gnt", 64'(gnt), 64'h0);
        step(1);
        check_ctl("preempt.grant1", 4'b0010, 2'd1, 1'b1);
        check("preempt.grant1.segs", segs, 64'h0);
        step(1);
        check("preempt.c1.segs", segs, D1);
        step(6);
        check("preempt.c1.last_own.gnt", 64'(gnt), 64'b0010);
        step(1);
        check_ctl("preempt.switch_back", 4'b0000, 2'd1, 1'b0);
        step(1);
        check("preempt.gap_back.gnt", 64'(gnt), 64'h0);
        step(1);
        check_ctl("preempt.grant0", 4'b0001, 2'd0, 1'b1);

        // 4: voluntary release after 3 OWN cycles
        req = 4'b0001;
        step(3);
        check("release.owning.gnt", 64'(gnt), 64'b0001);
        check("release.owning.segs", segs, D0);
        req = 4'b0000;
        step(1);
        check_ctl("release.switch", 4'b0000, 2'd0, 1'b0);
        check("release.switch.segs", segs, 64'h0);
        step(1);
        check("release.gap.gnt", 64'(gnt), 64'h0);
        step(2);
        check_ctl("release.idle", 4'b0000, 2'd0, 1'b0);
        check("release.idle.segs", segs, 64'h0);

        // 5: fairness with all clients requesting, starting from reset
        n_rst = 1'b0;
        step(1);
        n_rst = 1'b1;
        req   = 4'hF;
        step(1);
        for (int i = 0; i < 7; i++) begin
            check_ctl($sformatf("rr%0d.grant", i), 4'b0001 << order[i],
                      2'(order[i]), 1'b1);
            step(1);
            check($sformatf("rr%0d.segs", i), segs, dtab[order[i]]);
            if (i < 6) begin
                step(6);
                check($sformatf("rr%0d.own8.gnt", i), 64'(gnt),
                      64'(4'b0001 << order[i]));
                step(1);
                check($sformatf("rr%0d.gap1.gnt", i), 64'(gnt), 64'h0);
                check($sformatf("rr%0d.gap1.segs", i), segs, 64'h0);
                step(1);
                check($sformatf("rr%0d.gap2.busy", i), 64'(busy), 64'h0);
                step(1);
            end
        end

        // 6: reset for one edge while client 2 owns
        step(2);
        check_ctl("midown.before", 4'b0100, 2'd2, 1'b1);
        n_rst = 1'b0;
        step(1);
        check_ctl("midown.reset", 4'b0000, 2'd0, 1'b0);
        check("midown.reset.segs", segs, 64'h0);
        n_rst = 1'b1;
        req   = 4'b0101;
        step(1);
        check_ctl("midown.regrant", 4'b0001, 2'd0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
